// File: rtl/gshare_btb_pkg.sv
// Shared constants and types for the gshare branch predictor / BTB.
package gshare_btb_pkg;
    localparam int ADDR_W          = 32;
    localparam int DEF_BTB_ENTRIES = 64;
    localparam int DEF_PHT_ENTRIES = 256;
    localparam int DEF_GHR_LEN     = 8;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;
endpackage

// File: rtl/gshare_btb_sat.sv
// 2-bit saturating counter next-state logic for PHT training.
module sat_counter2
    import gshare_btb_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       inc,
    output logic [1:0] nxt
);
    always_comb begin
        nxt = cur;
        if (inc) begin
            if (cur != ST) nxt = cur + 2'd1;
        end else begin
            if (cur != SNT) nxt = cur - 2'd1;
        end
    end
endmodule

// File: rtl/gshare_btb.sv
// Gshare direction predictor plus direct-mapped BTB; combinational lookup,
// speculative global history with recovery from resolved mispredicts.
module gshare_btb
    import gshare_btb_pkg::*;
#(
    parameter int BTB_ENTRIES = DEF_BTB_ENTRIES,
    parameter int PHT_ENTRIES = DEF_PHT_ENTRIES,
    parameter int GHR_LEN     = DEF_GHR_LEN,
    localparam int GW         = (GHR_LEN > 0) ? GHR_LEN : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] pc_if,
    output logic              je,
    output logic [ADDR_W-1:0] jdest,
    output logic [GW-1:0]     pred_ghr,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_dest,
    input  logic [GW-1:0]     upd_ghr,
    input  logic              upd_mispredict
);
    localparam int BI = $clog2(BTB_ENTRIES);
    localparam int PI = $clog2(PHT_ENTRIES);
    localparam int TW = ADDR_W - BI - 2;

    logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
    logic [TW-1:0]          btb_tag_q [BTB_ENTRIES];
    logic [TW-1:0]          btb_tag_d [BTB_ENTRIES];
    logic [ADDR_W-1:0]      btb_tgt_q [BTB_ENTRIES];
    logic [ADDR_W-1:0]      btb_tgt_d [BTB_ENTRIES];
    logic [1:0]             pht_q [PHT_ENTRIES];
    logic [1:0]             pht_d [PHT_ENTRIES];
    logic [GW-1:0]          ghr_q, ghr_d;

    logic [BI-1:0] lk_bidx, up_bidx;
    logic [TW-1:0] lk_tag, up_tag;
    logic [PI-1:0] lk_pidx, up_pidx;
    logic          lk_hit, upd_en;
    logic [1:0]    ctr_nxt;
    logic [GW:0]   spec_w, rec_w;

    assign lk_bidx = pc_if[BI+1:2];
    assign lk_tag  = pc_if[ADDR_W-1:BI+2];
    assign lk_pidx = pc_if[PI+1:2] ^ PI'(ghr_q);
    assign up_bidx = upd_pc[BI+1:2];
    assign up_tag  = upd_pc[ADDR_W-1:BI+2];
    assign up_pidx = upd_pc[PI+1:2] ^ PI'(upd_ghr);
    assign upd_en  = upd_valid && !rst;

    // Lookup reads only _q state, so a same-cycle update is invisible here.
    assign lk_hit   = !rst && if_valid && btb_valid_q[lk_bidx] && (btb_tag_q[lk_bidx] == lk_tag);
    assign je       = lk_hit && pht_q[lk_pidx][1];
    assign jdest    = je ? btb_tgt_q[lk_bidx] : '0;
    assign pred_ghr = rst ? '0 : ghr_q;

    assign spec_w = {ghr_q, je};
    assign rec_w  = {upd_ghr, upd_taken};

    sat_counter2 u_ctr (
        .cur (pht_q[up_pidx]),
        .inc (upd_taken),
        .nxt (ctr_nxt)
    );

    always_comb begin
        btb_valid_d = btb_valid_q;
        btb_tag_d   = btb_tag_q;
        btb_tgt_d   = btb_tgt_q;
        pht_d       = pht_q;
        ghr_d       = ghr_q;
        if (upd_en) pht_d[up_pidx] = ctr_nxt;
        if (upd_en && upd_taken && !flush) begin
            btb_valid_d[up_bidx] = 1'b1;
            btb_tag_d[up_bidx]   = up_tag;
            btb_tgt_d[up_bidx]   = upd_dest;
        end
        if (flush) btb_valid_d = '0;
        // Recovery restores the committed path and beats any speculative shift.
        if (upd_en && upd_mispredict) ghr_d = rec_w[GW-1:0];
        else if (lk_hit)              ghr_d = spec_w[GW-1:0];
        if (GHR_LEN == 0) ghr_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid_q <= '0;
            for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= WNT;
            ghr_q <= '0;
        end else begin
            btb_valid_q <= btb_valid_d;
            pht_q       <= pht_d;
            ghr_q       <= ghr_d;
        end
        btb_tag_q <= btb_tag_d;
        btb_tgt_q <= btb_tgt_d;
    end

    logic unused_bits;
    assign unused_bits = ^{pc_if[1:0], upd_pc[1:0], spec_w[GW], rec_w[GW]};
endmodule

// File: tb/tb_gshare_btb.sv
// Directed bench for gshare_btb with default parameters (64/256/8).
module tb_gshare_btb;
    logic        clk = 1'b0;
    logic        rst, flush, if_valid;
    logic [31:0] pc_if;
    logic        je;
    logic [31:0] jdest;
    logic [7:0]  pred_ghr;
    logic        upd_valid, upd_taken, upd_mispredict;
    logic [31:0] upd_pc, upd_dest;
    logic [7:0]  upd_ghr;

    int tests = 0;
    int failed = 0;

    gshare_btb dut (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .pc_if(pc_if),
        .je(je), .jdest(jdest), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_dest(upd_dest), .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] dst,
                       input logic [7:0] g, input logic mis);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_dest = dst;
        upd_ghr = g; upd_mispredict = mis;
        tick();
        upd_valid = 1'b0; upd_mispredict = 1'b0;
    endtask

    // Look without committing: if_valid drops again before the edge.
    task automatic peek(input string tag, input logic [31:0] pc, input logic ej,
                        input logic [31:0] ed);
        if_valid = 1'b1; pc_if = pc;
        #1;
        chk({tag, "_je"}, {31'd0, je}, {31'd0, ej});
        chk({tag, "_jdest"}, jdest, ed);
        if_valid = 1'b0;
        tick();
    endtask

    task automatic fetch(input string tag, input logic [31:0] pc, input logic ej,
                         input logic [7:0] eg);
        if_valid = 1'b1; pc_if = pc;
        #1;
        chk({tag, "_je"}, {31'd0, je}, {31'd0, ej});
        chk({tag, "_ghr"}, {24'd0, pred_ghr}, {24'd0, eg});
        tick();
        if_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        if_valid = 1'b1; pc_if = 32'h1000;
        upd_valid = 1'b1; upd_pc = 32'h1000; upd_taken = 1'b1; upd_dest = 32'h2000;
        upd_ghr = 8'h0; upd_mispredict = 1'b1;
        tick(); tick();
        chk("rst_je", {31'd0, je}, 32'd0);
        chk("rst_jdest", jdest, 32'd0);
        chk("rst_ghr", {24'd0, pred_ghr}, 32'd0);
        rst = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0; if_valid = 1'b0;
        tick();

        peek("post_rst", 32'h1000, 1'b0, 32'h0);
        chk("post_rst_ghr", {24'd0, pred_ghr}, 32'd0);

        // Train: counter 1 -> 3, BTB entry written.
        upd(32'h1000, 1'b1, 32'h2000, 8'h0, 1'b0);
        upd(32'h1000, 1'b1, 32'h2000, 8'h0, 1'b0);
        peek("trained", 32'h1000, 1'b1, 32'h2000);

        // Untrain: 3 -> 2 (still taken) -> 1 -> 0 -> 0.
        upd(32'h1000, 1'b0, 32'h0, 8'h0, 1'b0);
        peek("nt1", 32'h1000, 1'b1, 32'h2000);
        upd(32'h1000, 1'b0, 32'h0, 8'h0, 1'b0);
        upd(32'h1000, 1'b0, 32'h0, 8'h0, 1'b0);
        upd(32'h1000, 1'b0, 32'h0, 8'h0, 1'b0);
        peek("nt4", 32'h1000, 1'b0, 32'h0);
        upd(32'h1000, 1'b0, 32'h0, 8'h0, 1'b0);
        // No underflow: one taken reaches only WNT, a second reaches WT.
        upd(32'h1000, 1'b1, 32'h2000, 8'h0, 1'b0);
        peek("sat0_t1", 32'h1000, 1'b0, 32'h0);
        upd(32'h1000, 1'b1, 32'h2000, 8'h0, 1'b0);
        peek("sat0_t2", 32'h1000, 1'b1, 32'h2000);

        // Alias: PHT slot of 0x1100 (0x40) made strongly taken; tag must still miss.
        upd(32'h1000, 1'b1, 32'h2000, 8'h40, 1'b0);
        upd(32'h1000, 1'b1, 32'h2000, 8'h40, 1'b0);
        peek("alias", 32'h1100, 1'b0, 32'h0);
        peek("alias_orig", 32'h1000, 1'b1, 32'h2000);

        // GHR: pht[0]=WT, pht[1]->WT, pht[3]=WNT gives predictions 1,1,0.
        upd(32'h1000, 1'b1, 32'h2000, 8'h01, 1'b0);
        fetch("ghr_f1", 32'h1000, 1'b1, 8'h00);
        fetch("ghr_f2", 32'h1000, 1'b1, 8'h01);
        fetch("ghr_f3", 32'h1000, 1'b0, 8'h03);
        chk("ghr_110", {24'd0, pred_ghr}, 32'h6);

        // Recovery in the same cycle as a hit (pht[6]=WNT) wins.
        if_valid = 1'b1; pc_if = 32'h1000;
        upd_valid = 1'b1; upd_pc = 32'h1000; upd_taken = 1'b1; upd_dest = 32'h2000;
        upd_ghr = 8'h01; upd_mispredict = 1'b1;
        #1;
        chk("rec_hit_je", {31'd0, je}, 32'd0);
        tick();
        if_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        chk("rec_ghr", {24'd0, pred_ghr}, 32'h3);

        // Recover history back to zero via a not-taken mispredict elsewhere.
        upd(32'h3004, 1'b0, 32'h0, 8'h0, 1'b1);
        chk("ghr_zero", {24'd0, pred_ghr}, 32'h0);

        // Read-during-write sees the old target.
        if_valid = 1'b1; pc_if = 32'h1000;
        upd_valid = 1'b1; upd_pc = 32'h1000; upd_taken = 1'b1; upd_dest = 32'h2400;
        upd_ghr = 8'h0; upd_mispredict = 1'b0;
        #1;
        chk("rdw_je", {31'd0, je}, 32'd1);
        chk("rdw_jdest", jdest, 32'h2000);
        if_valid = 1'b0;
        tick();
        upd_valid = 1'b0;
        peek("rdw_after", 32'h1000, 1'b1, 32'h2400);

        // Flush with a concurrent taken write: both discarded from BTB.
        flush = 1'b1;
        upd(32'h1000, 1'b1, 32'h2800, 8'h0, 1'b0);
        flush = 1'b0;
        peek("flush", 32'h1000, 1'b0, 32'h0);
        upd(32'h1000, 1'b1, 32'h2800, 8'h0, 1'b0);
        peek("retrain", 32'h1000, 1'b1, 32'h2800);

        // Mid-operation reset overrides recovery/update/flush.
        fetch("pre_rst", 32'h1000, 1'b1, 8'h00);
        chk("pre_rst_ghr", {24'd0, pred_ghr}, 32'h1);
        rst = 1'b1; flush = 1'b1; if_valid = 1'b1; pc_if = 32'h1000;
        upd_valid = 1'b1; upd_pc = 32'h1000; upd_taken = 1'b1; upd_dest = 32'h3000;
        upd_ghr = 8'h07; upd_mispredict = 1'b1;
        #1;
        chk("mid_rst_je", {31'd0, je}, 32'd0);
        chk("mid_rst_jdest", jdest, 32'd0);
        chk("mid_rst_ghr", {24'd0, pred_ghr}, 32'd0);
        tick();
        rst = 1'b0; flush = 1'b0; if_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        peek("after_rst", 32'h1000, 1'b0, 32'h0);
        chk("after_rst_ghr", {24'd0, pred_ghr}, 32'd0);
        // PHT reset to WNT: a single taken update reaches WT.
        upd(32'h1000, 1'b1, 32'h3000, 8'h0, 1'b0);
        peek("rst_pht_wnt", 32'h1000, 1'b1, 32'h3000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
